bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (32-bit, output register enabled) between two requesters, e.g. the AXI-slave BRAM controller and a core-side load/store unit.
- Round-robin arbitration with one access issued per cycle.
- Reads are pipelined, and each read response is routed back to its own requester after the fixed BRAM read latency.
- Writes are fire-and-forget.

Parameters:
- ADDR_W, 32, width of the address bus on both requester ports and on bram_addr.
- READ_LAT, 2, number of cycles from the cycle bram_* carries a read to the cycle bram_dout is valid. Legal range is 1 to 4.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- r0_valid  in  1  requester 0 access valid.
- r0_ready  out  1  requester 0 access accepted this cycle.
- r0_addr  in  ADDR_W  requester 0 byte address, 4-byte aligned.
- r0_we  in  4  requester 0 byte write strobes; 0 means read.
- r0_wdata  in  32  requester 0 write data.
- r0_rvalid  out  1  requester 0 read data valid.
- r0_rdata  out  32  requester 0 read data.
- r1_valid, r1_ready, r1_addr, r1_we, r1_wdata, r1_rvalid, r1_rdata: same as the r0_* ports, for requester 1.
- bram_addr  out  ADDR_W  BRAM address.
- bram_din  out  32  BRAM write data.
- bram_dout  in  32  BRAM read data.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.

Behaviour:
- Reset is asynchronous and active-low.
  - Outputs while rstn=0: r*_ready=0, r*_rvalid=0, r*_rdata=0, bram_addr=0, bram_din=0, bram_we=0, bram_en=1.
  - Internal state while rstn=0: round-robin pointer points to requester 0; in-flight read tracker cleared.
- Arbitration is combinational within a cycle.
  - If only one requester has valid=1, it gets ready=1.
  - If both have valid=1, ready=1 goes to the requester that was not granted last. After reset, requester 0 wins the first tie.
  - At most one ready is high per cycle.
  - ready may depend on valid; valid must not depend on ready.
- Acceptance occurs at a rising edge where valid=1 and ready=1 (call it edge T).
  - The pointer updates only on acceptance.
  - A requester may hold valid while not granted; its request is unchanged until accepted.
- Issue: the registered BRAM outputs carry the accepted access during the cycle after T.
  - bram_addr is the accepted address.
  - bram_we is the accepted we.
  - bram_din is the accepted wdata.
  - bram_en stays 1 at all times out of reset, because the BRAM output register needs it enabled continuously.
- Idle cycle (nothing accepted): bram_we=0; bram_addr and bram_din hold their previous values.
- Read completion (we=0): the arbiter pushes the requester ID into a READ_LAT+1 deep valid/ID shift register.
  - rN_rvalid pulses for exactly 1 cycle, READ_LAT+1 cycles after the issue cycle.
  - rN_rdata is registered from bram_dout in that cycle and holds until the next read response to the same requester.
  - Total read latency from acceptance edge to rvalid is READ_LAT+2 edges (4 at default).
  - No backpressure on responses: a requester must always accept rvalid.
- Write completion (we!=0): there is no response; r*_rvalid is not asserted.
- Ordering: accesses reach the BRAM in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data (BRAM is read-first per access, sequential in time).
- Back-to-back operation: full throughput of one access per cycle. Reads from both requesters may interleave every cycle; the tracker holds up to READ_LAT+1 outstanding reads.
- Reset mid-operation clears the tracker immediately. Pending responses are dropped, and no rvalid is asserted after rstn rises until new reads complete.
- Address width rule: the address passes through unmodified; no alignment checking.

Test Plan:
- Reset then single read: with BRAM preloaded [0x10]=0xDEADBEEF, r0 reads 0x10 → r0_ready=1 at once; r0_rvalid high exactly 4 edges after acceptance with r0_rdata=0xDEADBEEF; r1_rvalid stays 0.
- Write then read: r1 writes 0xA5A5A5A5 to 0x20 with we=0xF, then reads 0x20 on the next cycle → bram_we=0xF for 1 cycle; r1 receives 0xA5A5A5A5; no rvalid for the write.
- Byte strobes: preload 0x11223344 at 0x30; r0 writes 0xFFFFFFFF with we=0x2, then reads → 0x1122FF44.
- Contention: both requesters hold valid continuously for 8 reads each, first tie after reset → grants alternate r0, r1, r0, …; each requester receives its own 8 responses in order with correct data; bram_addr changes every cycle.
- Single requester streaming: r1 alone issues 6 consecutive reads to 0x0 through 0x14 → ready=1 every cycle; 6 consecutive rvalid cycles with data in address order.
- Reset mid-flight: 3 reads accepted, then rstn pulsed low for 1 cycle → all outputs return to reset values while low; no rvalid appears afterwards; next read after reset is granted to r0 on a tie.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side signals of the two-port BRAM arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              r0_valid;
  logic              r0_ready;
  logic [ADDR_W-1:0] r0_addr;
  logic [3:0]        r0_we;
  logic [31:0]       r0_wdata;
  logic              r0_rvalid;
  logic [31:0]       r0_rdata;

  logic              r1_valid;
  logic              r1_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic [3:0]        r1_we;
  logic [31:0]       r1_wdata;
  logic              r1_rvalid;
  logic [31:0]       r1_rdata;

  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_din;
  logic [31:0]       bram_dout;
  logic              bram_en;
  logic [3:0]        bram_we;

  modport slave (
    input  r0_valid, r0_addr, r0_we, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_addr, r1_we, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output bram_addr, bram_din, bram_en, bram_we,
    input  bram_dout
  );

  modport master (
    output r0_valid, r0_addr, r0_we, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_addr, r1_we, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  bram_addr, bram_din, bram_en, bram_we,
    output bram_dout
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters.
// Issues one access per cycle and routes read data back after the fixed BRAM latency.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic               clk,
  input  logic               rstn,
  bram_port_arbiter_if.slave bus
);

  localparam int unsigned TrkDepth = READ_LAT + 1;

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("bram_port_arbiter: READ_LAT must be within 1..4");
  end

  // prio_q set means requester 1 wins the next tie
  logic prio_q, prio_d;
  logic gnt0, gnt1, accept;

  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_we;
  logic [31:0]       acc_wdata;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [3:0]        we_q, we_d;

  logic [TrkDepth-1:0] trk_vld_q, trk_vld_d;
  logic [TrkDepth-1:0] trk_id_q, trk_id_d;
  logic                rsp_vld, rsp_id;

  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Ready is held low during reset even if valid is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      if (bus.r0_valid && (!bus.r1_valid || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (bus.r1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept = gnt0 | gnt1;

  always_comb begin
    acc_addr  = bus.r0_addr;
    acc_we    = bus.r0_we;
    acc_wdata = bus.r0_wdata;
    if (gnt1) begin
      acc_addr  = bus.r1_addr;
      acc_we    = bus.r1_we;
      acc_wdata = bus.r1_wdata;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  // Idle cycles drop the strobes but keep address/data stable.
  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = 4'b0000;
    if (accept) begin
      addr_d = acc_addr;
      din_d  = acc_wdata;
      we_d   = acc_we;
    end
  end

  // The last tracker stage lines up with the cycle bram_dout carries the read data.
  always_comb begin
    trk_vld_d = {trk_vld_q[TrkDepth-2:0], accept && (acc_we == 4'b0000)};
    trk_id_d  = {trk_id_q[TrkDepth-2:0], gnt1};
  end

  assign rsp_vld = trk_vld_q[TrkDepth-1];
  assign rsp_id  = trk_id_q[TrkDepth-1];

  always_comb begin
    rvalid0_d = rsp_vld && !rsp_id;
    rvalid1_d = rsp_vld && rsp_id;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (rvalid0_d) begin
      rdata0_d = bus.bram_dout;
    end
    if (rvalid1_d) begin
      rdata1_d = bus.bram_dout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= '0;
      trk_vld_q <= '0;
      trk_id_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      trk_vld_q <= trk_vld_d;
      trk_id_q  <= trk_id_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.r0_ready  = gnt0;
  assign bus.r1_ready  = gnt1;
  assign bus.r0_rvalid = rvalid0_q;
  assign bus.r1_rvalid = rvalid1_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  assign bus.bram_we   = we_q;
  // The BRAM output register must stay enabled, including through reset.
  assign bus.bram_en   = 1'b1;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.r0_ready && bus.r1_ready));

  a_single_response: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.r0_rvalid && bus.r1_rvalid));

endmodule
